// File: rtl/systolic_host_streamer.sv
// systolic_host_streamer: buffers one job's operands, streams them to the
// systolic array driver, flushes, then collects the MAC results.
module systolic_host_streamer #(
   parameter int width_p        = 32,
   parameter int array_width_p  = 8,
   parameter int array_height_p = 8,
   parameter int steps_p        = 8,
   parameter int settle_p       = 4,
   parameter int timeout_p      = 1024,
   localparam int n_in  = steps_p * (array_width_p + array_height_p),
   localparam int n_out = array_width_p * array_height_p,
   localparam int ia_w  = (n_in > 1) ? $clog2(n_in) : 1,
   localparam int ra_w  = (n_out > 1) ? $clog2(n_out) : 1
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               start_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               err_o,
   input  logic               op_we_i,
   input  logic [ia_w-1:0]    op_addr_i,
   input  logic [width_p-1:0] op_data_i,
   input  logic [ra_w-1:0]    res_addr_i,
   output logic [width_p-1:0] res_data_o,
   output logic               arr_valid_o,
   input  logic               arr_ready_i,
   output logic [width_p-1:0] arr_data_o,
   output logic               arr_flush_o,
   input  logic               arr_valid_i,
   output logic               arr_yumi_o,
   input  logic [width_p-1:0] arr_data_i
);

   localparam int sc_w = $clog2(settle_p + 1);
   localparam int to_w = $clog2(timeout_p + 1);

   typedef enum logic [2:0] {
      IDLE, STREAM, SETTLE, FLUSH, COLLECT, DONE
   } state_e;

   state_e state_q, state_d;

   logic [width_p-1:0] op_mem  [n_in];
   logic [width_p-1:0] res_mem [n_out];

   logic [ia_w-1:0] in_idx_q;
   logic [ra_w-1:0] out_idx_q;
   logic [sc_w-1:0] settle_q;
   logic [to_w-1:0] tmo_q;
   logic            err_q;

   logic start_acc, xfer, acc;
   logic last_in, last_out, settle_end, tmo_end;
   logic op_ok, res_ok;

   assign start_acc  = (state_q == IDLE) && start_i;
   assign xfer       = (state_q == STREAM) && arr_ready_i;
   assign acc        = (state_q == COLLECT) && arr_valid_i;
   assign last_in    = in_idx_q == ia_w'(n_in - 1);
   assign last_out   = out_idx_q == ra_w'(n_out - 1);
   assign settle_end = settle_q == sc_w'(settle_p - 1);
   assign tmo_end    = tmo_q == to_w'(timeout_p - 1);
   assign op_ok      = 32'(op_addr_i) < n_in;
   assign res_ok     = 32'(res_addr_i) < n_out;

   always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start_i) state_d = STREAM;
         STREAM:  if (arr_ready_i && last_in) state_d = SETTLE;
         SETTLE:  if (settle_end) state_d = FLUSH;
         FLUSH:   if (arr_ready_i) state_d = COLLECT;
         COLLECT: begin
            if (arr_valid_i) begin
               if (last_out) state_d = DONE;
            end else if (tmo_end) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_o      = state_q != IDLE;
      done_o      = state_q == DONE;
      arr_valid_o = state_q == STREAM;
      arr_flush_o = (state_q == FLUSH) && arr_ready_i;
      arr_yumi_o  = (state_q == COLLECT) && arr_valid_i;
   end

   assign arr_data_o = op_mem[in_idx_q];
   assign err_o      = err_q;

   // Indices saturate at the last entry; the state change ends the job.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         in_idx_q  <= '0;
         out_idx_q <= '0;
         settle_q  <= '0;
         tmo_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         if (start_acc) begin
            in_idx_q  <= '0;
            out_idx_q <= '0;
            settle_q  <= '0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
         end
         if (xfer && !last_in) in_idx_q <= in_idx_q + ia_w'(1);
         if ((state_q == SETTLE) && !settle_end)
            settle_q <= settle_q + sc_w'(1);
         if (acc) begin
            tmo_q <= '0;
            if (!last_out) out_idx_q <= out_idx_q + ra_w'(1);
         end else if (state_q == COLLECT) begin
            if (tmo_end) err_q <= 1'b1;
            else         tmo_q <= tmo_q + to_w'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (op_we_i && (state_q == IDLE) && op_ok)
         op_mem[op_addr_i] <= op_data_i;
      if (acc)
         res_mem[out_idx_q] <= arr_data_i;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i)     res_data_o <= '0;
      else if (res_ok) res_data_o <= res_mem[res_addr_i];
      else             res_data_o <= '0;
   end

endmodule
